traffic_light_counter: RTL and testbench

//  Per-phase down-counter for the traffic-light controller. The FSM loads the phase

---
 rtl/traffic_light_counter.sv | 58 +++++
 tb/tb_traffic_light_counter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_counter.sv
// Per-phase down-counter for the traffic-light controller: a one-hot init pulse loads the
// phase duration, en counts it down to a saturating zero, and last flags expiry.
module traffic_light_counter #(
   parameter int unsigned pGREEN_INIT_VAL  = 14,
   parameter int unsigned pYELLOW_INIT_VAL = 2,
   parameter int unsigned pRED_INIT_VAL    = 17,
   parameter int unsigned pCNT_WIDTH       = 5,
   parameter int unsigned pINIT_WIDTH      = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [pINIT_WIDTH-1:0] init,
   output logic                   last,
   output logic [pCNT_WIDTH-1:0]  cnt_out
);

   localparam logic [pCNT_WIDTH-1:0] GreenLoad  = pCNT_WIDTH'(pGREEN_INIT_VAL);
   localparam logic [pCNT_WIDTH-1:0] YellowLoad = pCNT_WIDTH'(pYELLOW_INIT_VAL);
   localparam logic [pCNT_WIDTH-1:0] RedLoad    = pCNT_WIDTH'(pRED_INIT_VAL);

   // A load value that does not fit the counter would be silently truncated.
   localparam bit CfgOk = ((pGREEN_INIT_VAL >> pCNT_WIDTH) == 0) &&
                          ((pYELLOW_INIT_VAL >> pCNT_WIDTH) == 0) &&
                          ((pRED_INIT_VAL >> pCNT_WIDTH) == 0) &&
                          (pINIT_WIDTH >= 3);

   logic [pCNT_WIDTH-1:0] cnt_q;
   logic [pCNT_WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      // Red outranks yellow, yellow outranks green; a load suppresses the decrement.
      if (init[2]) begin
         cnt_d = RedLoad;
      end else if (init[1]) begin
         cnt_d = YellowLoad;
      end else if (init[0]) begin
         cnt_d = GreenLoad;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
      assert (CfgOk)
         else $error("traffic_light_counter: init value exceeds pCNT_WIDTH range");
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_out = cnt_q;
   assign last    = (cnt_q == '0);

endmodule

// File: tb/tb_traffic_light_counter.sv
// Directed self-checking bench for traffic_light_counter: reset, per-phase countdown,
// load priority, pause/resume and asynchronous reset mid-count.
module tb_traffic_light_counter;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [2:0] init;
   logic       last;
   logic [4:0] cnt_out;

   int checks;
   int failures;

   traffic_light_counter dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .init    (init),
      .last    (last),
      .cnt_out (cnt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Advance one rising edge, then settle before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b0;
      init  = 3'b000;
      tick();
      tick();
      checks++;
      if (cnt_out !== 5'd0) begin
         failures++;
         $display("FAIL reset_cnt: cnt_out=%0d expected 0", cnt_out);
      end
      checks++;
      if (last !== 1'b1) begin
         failures++;
         $display("FAIL reset_last: last=%0b expected 1", last);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (cnt_out !== 5'd0 || last !== 1'b1) begin
         failures++;
         $display("FAIL reset_release: cnt_out=%0d last=%0b expected 0/1", cnt_out, last);
      end
      en = 1'b1;
      tick();
      tick();
      checks++;
      if (cnt_out !== 5'd0 || last !== 1'b1) begin
         failures++;
         $display("FAIL reset_en_saturate: cnt_out=%0d last=%0b expected 0/1", cnt_out, last);
      end
      en = 1'b0;
   endtask

   task automatic test_green();
      init = 3'b001;
      tick();
      checks++;
      if (cnt_out !== 5'd14 || last !== 1'b0) begin
         failures++;
         $display("FAIL green_load: cnt_out=%0d last=%0b expected 14/0", cnt_out, last);
      end
      init = 3'b000;
      en   = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         tick();
         checks++;
         if (cnt_out !== 5'(14 - i) || last !== (i == 14)) begin
            failures++;
            $display("FAIL green_count[%0d]: cnt_out=%0d last=%0b expected %0d/%0b",
                     i, cnt_out, last, 14 - i, (i == 14));
         end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (cnt_out !== 5'd0 || last !== 1'b1) begin
            failures++;
            $display("FAIL green_saturate[%0d]: cnt_out=%0d last=%0b expected 0/1",
                     i, cnt_out, last);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_yellow_red();
      init = 3'b010;
      tick();
      checks++;
      if (cnt_out !== 5'd2 || last !== 1'b0) begin
         failures++;
         $display("FAIL yellow_load: cnt_out=%0d last=%0b expected 2/0", cnt_out, last);
      end
      init = 3'b000;
      en   = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         tick();
         checks++;
         if (cnt_out !== 5'(2 - i) || last !== (i == 2)) begin
            failures++;
            $display("FAIL yellow_count[%0d]: cnt_out=%0d last=%0b expected %0d/%0b",
                     i, cnt_out, last, 2 - i, (i == 2));
         end
      end
      // en stays high across the red load: the load must win with no decrement.
      init = 3'b100;
      tick();
      checks++;
      if (cnt_out !== 5'd17 || last !== 1'b0) begin
         failures++;
         $display("FAIL red_load: cnt_out=%0d last=%0b expected 17/0", cnt_out, last);
      end
      init = 3'b000;
      for (int i = 1; i <= 17; i++) begin
         tick();
         checks++;
         if (cnt_out !== 5'(17 - i) || last !== (i == 17)) begin
            failures++;
            $display("FAIL red_count[%0d]: cnt_out=%0d last=%0b expected %0d/%0b",
                     i, cnt_out, last, 17 - i, (i == 17));
         end
      end
      en = 1'b0;
   endtask

   task automatic test_priority();
      en   = 1'b1;
      init = 3'b110;
      tick();
      checks++;
      if (cnt_out !== 5'd17) begin
         failures++;
         $display("FAIL prio_red_yellow: cnt_out=%0d expected 17", cnt_out);
      end
      init = 3'b111;
      tick();
      checks++;
      if (cnt_out !== 5'd17) begin
         failures++;
         $display("FAIL prio_all: cnt_out=%0d expected 17", cnt_out);
      end
      init = 3'b011;
      tick();
      checks++;
      if (cnt_out !== 5'd2) begin
         failures++;
         $display("FAIL prio_yellow_green: cnt_out=%0d expected 2", cnt_out);
      end
      init = 3'b000;
      tick();
      checks++;
      if (cnt_out !== 5'd1 || last !== 1'b0) begin
         failures++;
         $display("FAIL prio_then_count: cnt_out=%0d last=%0b expected 1/0", cnt_out, last);
      end
      en = 1'b0;
   endtask

   task automatic test_pause();
      init = 3'b001;
      tick();
      init = 3'b000;
      en   = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (cnt_out !== 5'(14 - i)) begin
            failures++;
            $display("FAIL pause_run[%0d]: cnt_out=%0d expected %0d", i, cnt_out, 14 - i);
         end
      end
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (cnt_out !== 5'd9 || last !== 1'b0) begin
            failures++;
            $display("FAIL pause_hold[%0d]: cnt_out=%0d last=%0b expected 9/0",
                     i, cnt_out, last);
         end
      end
      en = 1'b1;
      tick();
      checks++;
      if (cnt_out !== 5'd8) begin
         failures++;
         $display("FAIL pause_resume: cnt_out=%0d expected 8", cnt_out);
      end
      en = 1'b0;
   endtask

   task automatic test_async_reset();
      init = 3'b001;
      tick();
      init = 3'b000;
      en   = 1'b1;
      tick();
      tick();
      tick();
      checks++;
      if (cnt_out !== 5'd11) begin
         failures++;
         $display("FAIL arst_precount: cnt_out=%0d expected 11", cnt_out);
      end
      // Assert reset between edges; the clear must not wait for the next edge.
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (cnt_out !== 5'd0 || last !== 1'b1) begin
         failures++;
         $display("FAIL arst_immediate: cnt_out=%0d last=%0b expected 0/1", cnt_out, last);
      end
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if (cnt_out !== 5'd0 || last !== 1'b1) begin
         failures++;
         $display("FAIL arst_after_release: cnt_out=%0d last=%0b expected 0/1",
                  cnt_out, last);
      end
      init = 3'b100;
      tick();
      init = 3'b000;
      tick();
      checks++;
      if (cnt_out !== 5'd16) begin
         failures++;
         $display("FAIL arst_reload: cnt_out=%0d expected 16", cnt_out);
      end
      en = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      init     = 3'b000;
      test_reset();
      test_green();
      test_yellow_red();
      test_priority();
      test_pause();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
